// File: rtl/min_drain_pkg.sv
// Shared types and helpers for the sorted min-drainer (state encoding, one-hot decode, popcount test).
package min_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Helpers operate on a fixed maximum width; callers widen/truncate with explicit casts.
  localparam int unsigned MAX_CHANNELS    = 256;
  localparam int unsigned MAX_INDEX_WIDTH = 8;

  function automatic logic [MAX_INDEX_WIDTH-1:0] onehot_to_index(
    input logic [MAX_CHANNELS-1:0] onehot
  );
    logic [MAX_INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      if (onehot[i]) begin
        idx = idx | MAX_INDEX_WIDTH'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic popcount_is_one(input logic [MAX_CHANNELS-1:0] bits);
    return (bits != '0) && ((bits & (bits - MAX_CHANNELS'(1))) == '0);
  endfunction

endpackage

// File: rtl/min_index_select.sv
// Combinational log2-depth minimum finder over masked channels; ties resolve to the lowest index.
module min_index_select
  import min_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CHANNEL_COUNT = 8,
  localparam int unsigned INDEX_WIDTH  = $clog2(CHANNEL_COUNT)
) (
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
  input  logic [CHANNEL_COUNT-1:0]            mask,
  output logic [DATA_WIDTH-1:0]               min_value,
  output logic [INDEX_WIDTH-1:0]              min_index,
  output logic [CHANNEL_COUNT-1:0]            min_onehot,
  output logic                                any_valid
);

  localparam int unsigned LEAVES = 1 << INDEX_WIDTH;

  // Level 0 holds the (padded) leaves; each higher level halves the node count.
  for (genvar l = 0; l <= INDEX_WIDTH; l++) begin : g_lvl
    localparam int unsigned NODES = LEAVES >> l;
    logic [NODES*DATA_WIDTH-1:0] val;
    logic [NODES*LEAVES-1:0]     oh;
    logic [NODES-1:0]            vld;

    for (genvar n = 0; n < NODES; n++) begin : g_node
      if (l == 0) begin : g_leaf
        if (n < CHANNEL_COUNT) begin : g_chan
          assign val[n*DATA_WIDTH +: DATA_WIDTH] = values[n*DATA_WIDTH +: DATA_WIDTH];
          assign vld[n] = mask[n];
        end else begin : g_pad
          assign val[n*DATA_WIDTH +: DATA_WIDTH] = '0;
          assign vld[n] = 1'b0;
        end
        assign oh[n*LEAVES +: LEAVES] = LEAVES'(1) << n;
      end else begin : g_cmp
        logic [DATA_WIDTH-1:0] left_val;
        logic [DATA_WIDTH-1:0] right_val;
        logic [LEAVES-1:0]     left_oh;
        logic [LEAVES-1:0]     right_oh;
        logic                  left_vld;
        logic                  right_vld;
        logic                  take_left;

        assign left_val  = g_lvl[l-1].val[(2*n)*DATA_WIDTH +: DATA_WIDTH];
        assign right_val = g_lvl[l-1].val[(2*n+1)*DATA_WIDTH +: DATA_WIDTH];
        assign left_oh   = g_lvl[l-1].oh[(2*n)*LEAVES +: LEAVES];
        assign right_oh  = g_lvl[l-1].oh[(2*n+1)*LEAVES +: LEAVES];
        assign left_vld  = g_lvl[l-1].vld[2*n];
        assign right_vld = g_lvl[l-1].vld[2*n+1];

        // Left subtree covers lower indices, so it wins ties.
        assign take_left = left_vld && (!right_vld || (left_val <= right_val));

        assign val[n*DATA_WIDTH +: DATA_WIDTH] = take_left ? left_val : right_val;
        assign oh[n*LEAVES +: LEAVES]          = take_left ? left_oh  : right_oh;
        assign vld[n]                          = left_vld | right_vld;
      end
    end
  end

  logic [LEAVES-1:0] root_onehot;

  assign root_onehot = g_lvl[INDEX_WIDTH].oh;
  assign min_value   = g_lvl[INDEX_WIDTH].val;
  assign any_valid   = g_lvl[INDEX_WIDTH].vld[0];
  assign min_onehot  = root_onehot[CHANNEL_COUNT-1:0];
  assign min_index   = INDEX_WIDTH'(onehot_to_index(MAX_CHANNELS'(root_onehot)));

endmodule

// File: rtl/min_sorted_drainer.sv
// Captures a masked snapshot and streams its valid channels out in ascending value order.
// Optional MIN_DRAIN_FLUSH_EN adds a flush input that aborts a drain back to idle.
module min_sorted_drainer
  import min_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CHANNEL_COUNT = 8,
  localparam int unsigned INDEX_WIDTH  = $clog2(CHANNEL_COUNT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_valid,
  output logic                                load_ready,
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] load_values,
  input  logic [CHANNEL_COUNT-1:0]            load_valids,
`ifdef MIN_DRAIN_FLUSH_EN
  input  logic                                flush,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_value,
  output logic [INDEX_WIDTH-1:0]              out_index,
  output logic [CHANNEL_COUNT-1:0]            out_onehot,
  output logic                                out_last,
  output logic                                done,
  output logic                                busy
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);
  localparam logic [1:0] ST_EMIT = 2'(EMIT);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]                          state;
  logic [1:0]                          state_next;
  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] snap_values;
  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] snap_values_next;
  logic [CHANNEL_COUNT-1:0]            pending;
  logic [CHANNEL_COUNT-1:0]            pending_next;
  logic [DATA_WIDTH-1:0]               value_next;
  logic [INDEX_WIDTH-1:0]              index_next;
  logic [CHANNEL_COUNT-1:0]            onehot_next;
  logic                                last_next;
  logic                                abort;

  logic [DATA_WIDTH-1:0]               sel_value;
  logic [INDEX_WIDTH-1:0]              sel_index;
  logic [CHANNEL_COUNT-1:0]            sel_onehot;
  logic                                sel_any;

  min_index_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CHANNEL_COUNT (CHANNEL_COUNT)
  ) u_select (
    .values     (snap_values),
    .mask       (pending),
    .min_value  (sel_value),
    .min_index  (sel_index),
    .min_onehot (sel_onehot),
    .any_valid  (sel_any)
  );

`ifdef MIN_DRAIN_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  // Next-state and next-register logic.
  always_comb begin
    state_next       = state;
    snap_values_next = snap_values;
    pending_next     = pending;
    value_next       = out_value;
    index_next       = out_index;
    onehot_next      = out_onehot;
    last_next        = out_last;

    case (state)
      ST_IDLE: begin
        if (load_valid && !abort) begin
          snap_values_next = load_values;
          pending_next     = load_valids;
          state_next       = (load_valids != '0) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        value_next  = sel_value;
        index_next  = sel_index;
        onehot_next = sel_onehot;
        last_next   = popcount_is_one(MAX_CHANNELS'(pending));
        state_next  = sel_any ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        if (out_ready) begin
          pending_next = pending & ~out_onehot;
          state_next   = out_last ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort outside idle overrides everything, including a concurrent output handshake.
    if (abort && (state != ST_IDLE)) begin
      state_next   = ST_IDLE;
      pending_next = '0;
    end
  end

  // Status flags are registered from the upcoming state so they track it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      snap_values <= '0;
      pending     <= '0;
      out_value   <= '0;
      out_index   <= '0;
      out_onehot  <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_next;
      snap_values <= snap_values_next;
      pending     <= pending_next;
      out_value   <= value_next;
      out_index   <= index_next;
      out_onehot  <= onehot_next;
      out_last    <= last_next;
      out_valid   <= (state_next == ST_EMIT);
      done        <= (state_next == ST_DONE);
      busy        <= (state_next != ST_IDLE);
      load_ready  <= (state_next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_min_sorted_drainer.sv
// Directed bench for min_sorted_drainer: ordering, ties, masking, stalls, reset and optional flush.
module tb_min_sorted_drainer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_values;
  logic [7:0]  load_valids;
`ifdef MIN_DRAIN_FLUSH_EN
  logic        flush;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_value;
  logic [2:0]  out_index;
  logic [7:0]  out_onehot;
  logic        out_last;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  min_sorted_drainer #(
    .DATA_WIDTH    (8),
    .CHANNEL_COUNT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_values (load_values),
    .load_valids (load_valids),
`ifdef MIN_DRAIN_FLUSH_EN
    .flush       (flush),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_index   (out_index),
    .out_onehot  (out_onehot),
    .out_last    (out_last),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a snapshot in IDLE; for a non-empty mask, returns in the first EMIT cycle (T+2).
  task automatic do_load(input logic [63:0] vals, input logic [7:0] mask);
    check("load_ready_idle", 32'(load_ready), 32'd1);
    load_valid  = 1'b1;
    load_values = vals;
    load_valids = mask;
    step();
    load_valid  = 1'b0;
    load_values = {8{8'hA5}};
    load_valids = 8'hFF;
    if (mask != 8'h00) begin
      check("scan_no_valid", 32'(out_valid), 32'd0);
      check("scan_busy", 32'(busy), 32'd1);
      step();
    end
  endtask

  // Check the presented entry, accept it, then check the gap cycle (and done when last).
  task automatic take_entry(input logic [7:0] val, input logic [2:0] idx, input logic last);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    check("entry_valid", 32'(out_valid), 32'd1);
    check("entry_value", 32'(out_value), 32'(val));
    check("entry_index", 32'(out_index), 32'(idx));
    check("entry_onehot", 32'(out_onehot), 32'(oh));
    check("entry_last", 32'(out_last), 32'(last));
    out_ready = 1'b1;
    step();
    check("gap_no_valid", 32'(out_valid), 32'd0);
    if (last) begin
      check("done_pulse", 32'(done), 32'd1);
      step();
      check("done_cleared", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
      check("idle_load_ready", 32'(load_ready), 32'd1);
    end else begin
      check("no_early_done", 32'(done), 32'd0);
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_values = '0;
    load_valids = '0;
    out_ready   = 1'b1;
`ifdef MIN_DRAIN_FLUSH_EN
    flush       = 1'b0;
`endif
    step();
    step();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_onehot", 32'(out_onehot), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    step();

    // Distinct values {5,3,9,1}; masked-off upper channels hold 0, which must never appear
    do_load({8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9, 8'd3, 8'd5}, 8'h0F);
    take_entry(8'd1, 3'd3, 1'b0);
    take_entry(8'd3, 3'd1, 1'b0);
    take_entry(8'd5, 3'd0, 1'b0);
    take_entry(8'd9, 3'd2, 1'b1);

    // Equal values with channel 2 masked off: lowest index first, each emitted separately
    do_load({8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd2, 8'd7, 8'd7}, 8'b0000_1011);
    take_entry(8'd7, 3'd0, 1'b0);
    take_entry(8'd7, 3'd1, 1'b0);
    take_entry(8'd7, 3'd3, 1'b1);

    // Empty mask: done at T+1 with no entries, idle at T+2
    do_load({8{8'd4}}, 8'h00);
    check("empty_done", 32'(done), 32'd1);
    check("empty_no_valid", 32'(out_valid), 32'd0);
    step();
    check("empty_done_clear", 32'(done), 32'd0);
    check("empty_idle", 32'(load_ready), 32'd1);
    check("empty_not_busy", 32'(busy), 32'd0);

    // Back-pressure on the first entry: outputs hold for five cycles
    out_ready = 1'b0;
    do_load({8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9, 8'd3, 8'd5}, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_value", 32'(out_value), 32'd1);
      check("stall_index", 32'(out_index), 32'd3);
      check("stall_last", 32'(out_last), 32'd0);
      step();
    end
    take_entry(8'd1, 3'd3, 1'b0);
    take_entry(8'd3, 3'd1, 1'b0);
    take_entry(8'd5, 3'd0, 1'b0);
    take_entry(8'd9, 3'd2, 1'b1);

    // Reset during the second EMIT, then a fresh load using high channels
    do_load({8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9, 8'd3, 8'd5}, 8'h0F);
    take_entry(8'd1, 3'd3, 1'b0);
    check("second_emit_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_load_ready", 32'(load_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_value", 32'(out_value), 32'd0);
    step();
    check("postrst_no_done", 32'(done), 32'd0);
    check("postrst_idle", 32'(busy), 32'd0);
    do_load({8'd200, 8'd1, 8'd1, 8'd1, 8'd2, 8'd6, 8'd8, 8'd4}, 8'b1000_0110);
    take_entry(8'd6, 3'd2, 1'b0);
    take_entry(8'd8, 3'd1, 1'b0);
    take_entry(8'd200, 3'd7, 1'b1);

`ifdef MIN_DRAIN_FLUSH_EN
    // Flush during SCAN aborts the drain silently
    load_valid  = 1'b1;
    load_values = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd9, 8'd3, 8'd5};
    load_valids = 8'h0F;
    step();
    load_valid = 1'b0;
    check("fl_in_scan", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_load_ready", 32'(load_ready), 32'd1);
    check("fl_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_quiet_valid", 32'(out_valid), 32'd0);
      check("fl_quiet_done", 32'(done), 32'd0);
    end

    // Flush with load_valid in IDLE: no capture
    load_valid  = 1'b1;
    load_valids = 8'h0F;
    flush       = 1'b1;
    step();
    load_valid = 1'b0;
    flush      = 1'b0;
    check("fl_idle_busy", 32'(busy), 32'd0);
    check("fl_idle_ready", 32'(load_ready), 32'd1);
    step();
    check("fl_idle_no_valid", 32'(out_valid), 32'd0);
    check("fl_idle_no_done", 32'(done), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
